// File: rtl/ffapuf_eval_ctrl.sv
// Evaluation controller for one feed-forward arbiter PUF slice: repeated evaluation, majority vote, word assembly.
// Latency: a word is presented RESP_BITS*(NUM_EVAL*(SETTLE_CYC+3)+1) cycles after start is accepted.
// Backpressure: the finished word is held in DONE with resp_valid high until resp_ready; start is ignored meanwhile.
module ffapuf_eval_ctrl #(
   parameter int CHAL_W     = 3,
   parameter int RESP_BITS  = 8,
   parameter int NUM_EVAL   = 5,
   parameter int SETTLE_CYC = 4
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic [CHAL_W-1:0]    chal_seed,
   output logic [CHAL_W-1:0]    puf_chal,
   output logic                 puf_clr,
   output logic                 puf_exc,
   input  logic                 puf_r,
   output logic [RESP_BITS-1:0] resp,
   output logic [RESP_BITS-1:0] unstable,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 busy
);

   // Counter widths: ones/eval_cnt must hold NUM_EVAL, bit_idx indexes the word.
   localparam int CNT_W = $clog2(NUM_EVAL + 1);
   localparam int BIT_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [CNT_W-1:0] EVAL_LAST  = CNT_W'(NUM_EVAL - 1);
   localparam logic [CNT_W-1:0] EVAL_ALL   = CNT_W'(NUM_EVAL);
   localparam logic [CNT_W-1:0] EVAL_HALF  = CNT_W'(NUM_EVAL / 2);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(RESP_BITS - 1);
   localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE_CYC - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLEAR  = 3'd1;
   localparam logic [2:0] ST_ARM    = 3'd2;
   localparam logic [2:0] ST_EXCITE = 3'd3;
   localparam logic [2:0] ST_SAMPLE = 3'd4;
   localparam logic [2:0] ST_VOTE   = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   logic [2:0]           state_q,    state_d;
   logic [CNT_W-1:0]     eval_cnt_q, eval_cnt_d;
   logic [CNT_W-1:0]     ones_q,     ones_d;
   logic [BIT_W-1:0]     bit_idx_q,  bit_idx_d;
   logic [SET_W-1:0]     settle_q,   settle_d;
   logic [CHAL_W-1:0]    chal_q,     chal_d;
   logic [RESP_BITS-1:0] resp_q,     resp_d;
   logic [RESP_BITS-1:0] unst_q,     unst_d;
   logic                 valid_q,    valid_d;
   logic                 pclr_q,     pclr_d;
   logic                 pexc_q,     pexc_d;
   logic                 busy_q,     busy_d;
   logic                 r_meta_q;
   logic                 r_sync_q;

   // Two-flop synchroniser: the slice response settles asynchronously to clk.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_meta_q <= 1'b0;
         r_sync_q <= 1'b0;
      end else begin
         r_meta_q <= puf_r;
         r_sync_q <= r_meta_q;
      end
   end

   // Sequencer: clear -> arm -> excite -> sample per evaluation, vote per bit, hold word in DONE.
   always_comb begin
      state_d    = state_q;
      eval_cnt_d = eval_cnt_q;
      ones_d     = ones_q;
      bit_idx_d  = bit_idx_q;
      settle_d   = settle_q;
      chal_d     = chal_q;
      resp_d     = resp_q;
      unst_d     = unst_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               chal_d     = chal_seed;
               bit_idx_d  = '0;
               eval_cnt_d = '0;
               ones_d     = '0;
               resp_d     = '0;
               unst_d     = '0;
               state_d    = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            state_d = ST_ARM;
         end
         ST_ARM: begin
            settle_d = '0;
            state_d  = ST_EXCITE;
         end
         ST_EXCITE: begin
            if (settle_q == SETTLE_END) begin
               state_d = ST_SAMPLE;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_SAMPLE: begin
            ones_d = ones_q + CNT_W'(r_sync_q);
            if (eval_cnt_q == EVAL_LAST) begin
               state_d = ST_VOTE;
            end else begin
               eval_cnt_d = eval_cnt_q + 1'b1;
               state_d    = ST_CLEAR;
            end
         end
         ST_VOTE: begin
            // Strict majority of an odd count; any split marks the bit unstable.
            resp_d[bit_idx_q] = (ones_q > EVAL_HALF);
            unst_d[bit_idx_q] = (ones_q != '0) && (ones_q != EVAL_ALL);
            chal_d            = chal_q + 1'b1;
            ones_d            = '0;
            eval_cnt_d        = '0;
            if (bit_idx_q == BIT_LAST) begin
               state_d = ST_DONE;
            end else begin
               bit_idx_d = bit_idx_q + 1'b1;
               state_d   = ST_CLEAR;
            end
         end
         ST_DONE: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output next-state: outputs are decoded from the next state so they are registered yet aligned to it.
   always_comb begin
      valid_d = (state_d == ST_DONE);
      pexc_d  = (state_d == ST_EXCITE);
      pclr_d  = (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_DONE);
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any word in flight.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= ST_IDLE;
         eval_cnt_q <= '0;
         ones_q     <= '0;
         bit_idx_q  <= '0;
         settle_q   <= '0;
         chal_q     <= '0;
         resp_q     <= '0;
         unst_q     <= '0;
         valid_q    <= 1'b0;
         pclr_q     <= 1'b1;
         pexc_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         eval_cnt_q <= eval_cnt_d;
         ones_q     <= ones_d;
         bit_idx_q  <= bit_idx_d;
         settle_q   <= settle_d;
         chal_q     <= chal_d;
         resp_q     <= resp_d;
         unst_q     <= unst_d;
         valid_q    <= valid_d;
         pclr_q     <= pclr_d;
         pexc_q     <= pexc_d;
         busy_q     <= busy_d;
      end
   end

   assign puf_chal   = chal_q;
   assign puf_clr    = pclr_q;
   assign puf_exc    = pexc_q;
   assign resp       = resp_q;
   assign unstable   = unst_q;
   assign resp_valid = valid_q;
   assign busy       = busy_q;

endmodule

// File: doc/ffapuf_eval_ctrl.md
Name: ffapuf_eval_ctrl

Overview:
Evaluation controller that sits directly around one feed-forward arbiter PUF slice. It drives the slice's challenge, clear and excitation inputs, and samples the slice's single-bit response. Each response bit is evaluated NUM_EVAL times and majority-voted, and stability per bit is flagged. RESP_BITS voted bits are assembled into a response word and handed downstream with a valid/ready handshake.

Parameters:
CHAL_W, 3, challenge width driven to the slice
RESP_BITS, 8, voted bits per response word
NUM_EVAL, 5, evaluations per bit; must be odd, >=1
SETTLE_CYC, 4, cycles puf_exc is held high before sampling; must be >=3 (covers 2-flop sync)

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-low
start  in  1  request one response word; sampled only in IDLE
chal_seed  in  CHAL_W  first challenge of the word; latched on accepted start
puf_chal  out  CHAL_W  challenge to slice C input
puf_clr  out  1  clear to slice flops, active-high
puf_exc  out  1  excitation edge to slice clk input
puf_r  in  1  slice response; asynchronous to clk
resp  out  RESP_BITS  voted response word; bit i corresponds to challenge seed+i
unstable  out  RESP_BITS  bit i set if evaluations of bit i disagreed
resp_valid  out  1  resp/unstable valid
resp_ready  in  1  downstream accepts
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (clr low, async) values: state IDLE, puf_clr=1, puf_exc=0, puf_chal=0, resp=0, unstable=0, resp_valid=0, busy=0. Sync flops, counters and ones accumulator = 0. Reset mid-operation aborts the word; no partial output.
- puf_r passes through a 2-flop synchroniser. Only the synchronised value is used.
- All outputs are registered.
- IDLE: puf_clr held 1, puf_exc 0.
  - On start=1: latch chal_seed into puf_chal, bit_idx=0, eval_cnt=0, ones=0, then go to CLEAR.
- CLEAR (1 cycle): puf_clr=1, puf_exc=0, then go to ARM.
- ARM (1 cycle): puf_clr=0, puf_exc=0, then go to EXCITE.
- EXCITE (SETTLE_CYC cycles): puf_exc=1, puf_clr=0, then go to SAMPLE.
- SAMPLE (1 cycle): ones += synchronised puf_r, puf_exc=0.
  - If eval_cnt==NUM_EVAL-1, go to VOTE.
  - Otherwise eval_cnt++ and go to CLEAR.
- VOTE (1 cycle):
  - resp[bit_idx] = (ones > NUM_EVAL/2).
  - unstable[bit_idx] = (ones != 0 && ones != NUM_EVAL).
  - puf_chal += 1, mod 2^CHAL_W (wraps).
  - ones=0, eval_cnt=0.
  - If bit_idx==RESP_BITS-1, go to DONE. Otherwise bit_idx++ and go to CLEAR.
- DONE: resp_valid=1; resp and unstable stable. puf_clr=1.
  - On resp_ready=1, resp_valid drops next cycle and state goes to IDLE.
  - resp and unstable keep their values until the next accepted start, which clears both.
- start outside IDLE is ignored, including in DONE. start and resp_ready both high in DONE: handshake completes; start is not accepted that cycle.
- Timing:
  - Per evaluation: SETTLE_CYC+3 cycles.
  - Per bit: NUM_EVAL*(SETTLE_CYC+3)+1 cycles.
  - DONE is entered RESP_BITS*(NUM_EVAL*(SETTLE_CYC+3)+1) edges after the edge that accepts start.
- Counter widths: ones and eval_cnt are clog2(NUM_EVAL+1) bits; bit_idx is clog2(RESP_BITS) bits (min 1).

Test Plan:
- Defaults, puf_r tied 1, start with seed 0 -> resp_valid rises 288 cycles after start; resp=8'hFF, unstable=8'h00; puf_exc shows 40 high pulses of 4 cycles each.
- puf_r tied 0, seed 5 -> resp=8'h00, unstable=8'h00; puf_chal steps 5,6,7,0,1,2,3,4 (wrap), one value per 36-cycle bit window.
- puf_r driven 1 on evaluations 0,2,4 of bit 2 only and 0 elsewhere -> resp=8'h04, unstable=8'h04. Driving 1 on evaluations 0,1 of bit 3 -> resp bit3=0, unstable bit3=1.
- Hold resp_ready=0 for 50 cycles in DONE, toggling start -> resp_valid stays 1, resp unchanged, no new word starts. Raise resp_ready -> IDLE next cycle, busy=0.
- Assert clr low during EXCITE of bit 4 -> all outputs immediately return to reset values (puf_clr=1, puf_exc=0, resp_valid=0). A new start produces a full correct word.
- start pulsed while busy -> ignored; word completes with the original seed.
